// File: rtl/uart_rx_sampler.sv
// 8N1 serial receiver front end: 2-flop sync, 3-sample majority vote, bit-timing FSM,
// framing-error and line-break detection. One-cycle stop strobe per good byte.
module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 104,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2,
  parameter int BREAK_BITS   = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] out,
  output logic       stop,
  output logic       frame_err,
  output logic       break_det,
  output logic       active
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int BRK = BREAK_BITS * CLKS_PER_BIT;
  localparam int LW  = $clog2(BRK + 1);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] LOW_MAX  = LW'(BRK);
  localparam logic [LW-1:0] LOW_HIT  = LW'(BRK - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       stop;
    logic       ferr;
  } rx_rsp_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bidx, bidx_n;
  logic [7:0]    shreg, shreg_n;
  rx_rsp_t       rsp, rsp_n;

  logic [1:0]    sync;
  logic [1:0]    hist;
  logic          rx_s;
  logic          vote;
  logic [LW-1:0] lowcnt;

  assign rx_s = sync[1];
  assign vote = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);

  // Line idles high, so sync and vote history reset to 1 to avoid a false start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= 2'b11;
      hist <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
      hist <= {hist[0], rx_s};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      bidx  <= '0;
      shreg <= '0;
      rsp   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bidx  <= bidx_n;
      shreg <= shreg_n;
      rsp   <= rsp_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bidx_n    = bidx;
    shreg_n   = shreg;
    rsp_n     = rsp;
    rsp_n.stop = 1'b0;
    rsp_n.ferr = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n = '0;
          if (vote) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            bidx_n  = '0;
          end
        end
      end
      DATA: begin
        if (cnt == CNT_BIT) begin
          cnt_n   = '0;
          shreg_n = {vote, shreg[7:1]};
          bidx_n  = bidx + 3'd1;
          if (bidx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_BIT) begin
          cnt_n = '0;
          if (vote) begin
            state_n    = IDLE;
            rsp_n.data = shreg;
            rsp_n.stop = 1'b1;
          end else begin
            state_n    = WAIT_HIGH;
            rsp_n.ferr = 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        // Hold off until the line is released so a stuck-low line can't retrigger.
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lowcnt    <= '0;
      break_det <= 1'b0;
    end else if (rx_s) begin
      lowcnt    <= '0;
      break_det <= 1'b0;
    end else begin
      if (lowcnt != LOW_MAX) lowcnt <= lowcnt + 1'b1;
      if (lowcnt == LOW_HIT) break_det <= 1'b1;
    end
  end

  assign out       = rsp.data;
  assign stop      = rsp.stop;
  assign frame_err = rsp.ferr;
  assign active    = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler at 16 clocks/bit: frame table plus hand-written
// latency, back-to-back, glitch, break and mid-frame reset sequences.
module tb_uart_rx_sampler;

  localparam int CPB = 16;

  logic       clk, reset, rx;
  logic [7:0] out;
  logic       stop, frame_err, break_det, active;

  uart_rx_sampler #(.CLKS_PER_BIT(CPB), .BREAK_BITS(12)) dut (
    .clk(clk), .reset(reset), .rx(rx), .out(out), .stop(stop),
    .frame_err(frame_err), .break_det(break_det), .active(active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_stop = 0, n_ferr = 0, act_cnt = 0;
  int last_stop = 0, prev_stop = 0, fall_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (stop) begin
      n_stop++;
      prev_stop = last_stop;
      last_stop = cyc;
    end
    if (frame_err) n_ferr++;
    if (active) act_cnt++;
    if (stop && frame_err) begin
      n_bad++;
      $display("FAIL stop_ferr_excl: both high at cycle %0d", cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Tasks begin and end 1 time unit after a rising edge.
  task automatic send_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_lvl);
    fall_cyc = cyc;
    send_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) send_bit(d[i], CPB);
    send_bit(stop_lvl, CPB);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_lvl;
    logic [7:0] exp_out;
    int         exp_stops;
    int         exp_ferr;
  } vec_t;

  vec_t vt[8];

  initial begin
    int s0, f0;
    vt[0] = '{8'h41, 1'b1, 8'h41, 1, 0};
    vt[1] = '{8'h55, 1'b0, 8'h41, 0, 1};
    vt[2] = '{8'h30, 1'b1, 8'h30, 1, 0};
    vt[3] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
    vt[4] = '{8'h00, 1'b1, 8'h00, 1, 0};
    vt[5] = '{8'h80, 1'b1, 8'h80, 1, 0};
    vt[6] = '{8'h01, 1'b1, 8'h01, 1, 0};
    vt[7] = '{8'hC3, 1'b0, 8'h01, 0, 1};

    rx = 1'b1;
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_out", {24'h0, out}, 32'h0);
    check("rst_flags", {28'h0, stop, frame_err, break_det, active}, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    send_bit(1'b1, 10);

    // Table: frame, idle gap, then compare out and strobe counts.
    for (int i = 0; i < 8; i++) begin
      s0 = n_stop;
      f0 = n_ferr;
      send_frame(vt[i].data, vt[i].stop_lvl);
      send_bit(1'b1, 20);
      check($sformatf("tbl%0d_out", i), {24'h0, out}, {24'h0, vt[i].exp_out});
      check($sformatf("tbl%0d_stops", i), n_stop - s0, vt[i].exp_stops);
      check($sformatf("tbl%0d_ferr", i), n_ferr - f0, vt[i].exp_ferr);
    end

    // Latency from rx falling edge to stop strobe: 155 +/- 1.
    send_frame(8'h41, 1'b1);
    send_bit(1'b1, 10);
    check("latency_155", (last_stop - fall_cyc >= 154) && (last_stop - fall_cyc <= 156), 1);
    check("latency_out", {24'h0, out}, 32'h41);

    // Back-to-back frames, stop bit exactly one bit time.
    s0 = n_stop;
    send_frame(8'h0D, 1'b1);
    check("b2b_first", {24'h0, out}, 32'h0D);
    send_frame(8'h39, 1'b1);
    send_bit(1'b1, 10);
    check("b2b_second", {24'h0, out}, 32'h39);
    check("b2b_count", n_stop - s0, 2);
    check("b2b_spacing", last_stop - prev_stop, 160);

    // Short low glitch on idle line.
    s0 = n_stop;
    f0 = n_ferr;
    act_cnt = 0;
    send_bit(1'b0, 3);
    send_bit(1'b1, 30);
    check("glitch_nostop", n_stop - s0, 0);
    check("glitch_noferr", n_ferr - f0, 0);
    check("glitch_active", (act_cnt > 0) && (act_cnt <= 10), 1);

    // Bad stop bit keeps the previous byte; next good byte recovers.
    s0 = n_stop;
    f0 = n_ferr;
    send_frame(8'h55, 1'b0);
    send_bit(1'b1, 20);
    check("ferr_once", n_ferr - f0, 1);
    check("ferr_keep_out", {24'h0, out}, 32'h39);
    check("ferr_nostop", n_stop - s0, 0);
    send_frame(8'h30, 1'b1);
    send_bit(1'b1, 10);
    check("ferr_recover", {24'h0, out}, 32'h30);

    // Line break: 200 low cycles.
    f0 = n_ferr;
    s0 = n_stop;
    send_bit(1'b0, 189);
    check("brk_not_yet", {31'h0, break_det}, 0);
    send_bit(1'b0, 11);
    check("brk_set", {31'h0, break_det}, 1);
    send_bit(1'b1, 2);
    check("brk_hold_sync", {31'h0, break_det}, 1);
    send_bit(1'b1, 1);
    check("brk_clear", {31'h0, break_det}, 0);
    send_bit(1'b1, 20);
    check("brk_one_ferr", n_ferr - f0, 1);
    check("brk_nostop", n_stop - s0, 0);
    send_frame(8'hC3, 1'b1);
    send_bit(1'b1, 10);
    check("brk_next_byte", {24'h0, out}, 32'hC3);

    // Asynchronous reset in the middle of DATA.
    s0 = n_stop;
    send_bit(1'b0, CPB);
    send_bit(1'b1, CPB);
    send_bit(1'b0, CPB);
    send_bit(1'b1, CPB / 2);
    reset = 1'b1;
    #1;
    check("mrst_out", {24'h0, out}, 32'h0);
    check("mrst_flags", {28'h0, stop, frame_err, break_det, active}, 32'h0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    send_bit(1'b1, 40);
    check("mrst_nostop", n_stop - s0, 0);
    send_frame(8'hA5, 1'b1);
    send_bit(1'b1, 10);
    check("mrst_next_out", {24'h0, out}, 32'hA5);
    check("mrst_next_cnt", n_stop - s0, 1);
    check("idle_inactive", {31'h0, active}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
